// File: rtl/fir_decim_out_buffer_pkg.sv
// Shared constants for the FIR output path: sample format, filter order and buffer defaults.
package fir_decim_out_buffer_pkg;

    localparam int SAMPLE_W       = 16;
    localparam int FIR_ORDER      = 7;
    localparam int DECIM_DEF      = 4;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [0:0] ST_WARMUP = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

endpackage

// File: rtl/fir_decim_out_buffer_sync.sv
// First-word-fall-through synchronous FIFO; head word is visible on rd_data whenever not empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// Drops FIR start-up samples, keeps one in DECIM afterwards and buffers kept samples for a stallable consumer.
module fir_decim_out_buffer
    import fir_decim_out_buffer_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_W,
    parameter int DECIM      = DECIM_DEF,
    parameter int WARMUP     = FIR_ORDER,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              fir_y,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int         PH_W     = $clog2(DECIM + 1);
    localparam int         WC_W     = $clog2(WARMUP + 1) + 1;
    localparam logic [0:0] ST_RESET = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    logic [0:0]      r_state;
    logic [PH_W-1:0] r_phase;
    logic [WC_W-1:0] r_warm_cnt;
    logic            r_overflow;
    logic            w_keep;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_full;
    logic            w_empty;

    assign w_pop     = out_valid && out_ready;
    assign w_keep    = (r_state == ST_RUN) && (r_phase == '0);
    assign w_push    = w_keep && (!w_full || w_pop);
    assign w_drop    = w_keep && w_full && !w_pop;
    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_RESET;
            r_warm_cnt <= '0;
            r_phase    <= '0;
        end else if (r_state == ST_WARMUP) begin
            r_warm_cnt <= r_warm_cnt + WC_W'(1);
            if (r_warm_cnt == WC_W'(WARMUP - 1)) begin
                r_state <= ST_RUN;
            end
        end else begin
            r_phase <= (r_phase == PH_W'(DECIM - 1)) ? '0 : r_phase + PH_W'(1);
        end
    end

    // A drop in the same cycle as a clear must leave the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (fir_y),
        .rd_en   (w_pop),
        .rd_data (out_data),
        .count   (fill_level),
        .full    (w_full),
        .empty   (w_empty)
    );

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Directed bench: instance A (DECIM=4, WARMUP=7) covers warm-up, decimation, overflow and reset; B (DECIM=1, WARMUP=0) covers bit-exact pass-through.
module tb_fir_decim_out_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_ready, a_clr, a_valid, a_ovf;
    logic [15:0] a_fir_y, a_data;
    logic [3:0]  a_fill;
    logic        b_reset, b_ready, b_clr, b_valid, b_ovf;
    logic [15:0] b_fir_y, b_data;
    logic [3:0]  b_fill;

    int n_vec  = 0;
    int n_miss = 0;
    int k;

    fir_decim_out_buffer #(
        .WIDTH (16), .DECIM (4), .WARMUP (7), .FIFO_DEPTH (8)
    ) u_dut_a (
        .clk (clk), .reset (a_reset), .fir_y (a_fir_y), .out_data (a_data),
        .out_valid (a_valid), .out_ready (a_ready), .overflow (a_ovf),
        .clr_overflow (a_clr), .fill_level (a_fill)
    );

    fir_decim_out_buffer #(
        .WIDTH (16), .DECIM (1), .WARMUP (0), .FIFO_DEPTH (8)
    ) u_dut_b (
        .clk (clk), .reset (b_reset), .fir_y (b_fir_y), .out_data (b_data),
        .out_valid (b_valid), .out_ready (b_ready), .overflow (b_ovf),
        .clr_overflow (b_clr), .fill_level (b_fill)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a();
        a_fir_y = 16'(k);
        step();
        k++;
    endtask

    initial begin
        int s;
        int n_kept;

        a_reset = 1'b0; a_ready = 1'b0; a_clr = 1'b0; a_fir_y = '0;
        b_reset = 1'b0; b_ready = 1'b0; b_clr = 1'b0; b_fir_y = '0;
        step();

        // Reset state
        check("rst_valid", a_valid, 0);
        check("rst_data",  a_data,  0);
        check("rst_ovf",   a_ovf,   0);
        check("rst_fill",  a_fill,  0);

        // 1: warm-up discards 1..7, then keeps 8,12,16,... with one-cycle latency
        a_reset = 1'b1;
        a_ready = 1'b1;
        k = 1;
        repeat (30) begin
            s = k;
            feed_a();
            if (s >= 8 && s % 4 == 0) begin
                check("t1_valid", a_valid, 1);
                check("t1_data",  a_data,  s);
            end else begin
                check("t1_idle", a_valid, 0);
            end
        end
        check("t1_ovf", a_ovf, 0);

        // 2: consumer stalled for 40 kept periods; 9th kept sample overflows
        a_ready = 1'b0;
        n_kept  = 0;
        repeat (160) begin
            s = k;
            feed_a();
            if (s % 4 == 0) begin
                n_kept++;
                check("t2_fill", a_fill, (n_kept > 8) ? 8 : n_kept);
                check("t2_ovf",  a_ovf,  (n_kept >= 9) ? 1 : 0);
            end
        end
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t2_drain", a_data, 32 + 4 * i);
            feed_a();
        end
        check("t2_fill_after", a_fill, 2);
        check("t2_head_after", a_data, 192);
        repeat (3) feed_a();
        check("t2_empty", a_valid, 0);
        a_clr = 1'b1;
        feed_a();
        a_clr = 1'b0;
        check("t6_clr_nodrop", a_ovf, 0);

        // 3: full FIFO, ready only in the kept cycle -> push accepted, no overflow
        a_ready = 1'b0;
        repeat (33) feed_a();
        check("t3_full",  a_fill, 8);
        check("t3_head",  a_data, 204);
        a_ready = 1'b1;
        feed_a();
        a_ready = 1'b0;
        check("t3_fill", a_fill, 8);
        check("t3_ovf",  a_ovf,  0);
        check("t3_head2", a_data, 208);

        // 6: drop sets overflow; clear in a drop cycle loses; clear in a quiet cycle wins
        repeat (4) feed_a();
        check("t6_drop", a_ovf, 1);
        repeat (3) feed_a();
        a_clr = 1'b1;
        feed_a();
        check("t6_clr_drop", a_ovf, 1);
        feed_a();
        a_clr = 1'b0;
        check("t6_clr_quiet", a_ovf, 0);
        check("t6_fill", a_fill, 8);

        // 4: bring fill to 5, pulse reset, warm-up restarts
        a_ready = 1'b1;
        repeat (4) feed_a();
        a_ready = 1'b0;
        check("t4_fill5", a_fill, 5);
        check("t4_head",  a_data, 224);
        a_reset = 1'b0;
        feed_a();
        a_reset = 1'b1;
        check("t4_fill0", a_fill, 0);
        check("t4_valid", a_valid, 0);
        check("t4_data",  a_data, 0);
        a_ready = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            s = k;
            feed_a();
            if (j >= 8 && (j - 8) % 4 == 0) begin
                check("t4_kept_valid", a_valid, 1);
                check("t4_kept_data",  a_data,  s);
            end else begin
                check("t4_discard", a_valid, 0);
            end
        end

        // 5: DECIM=1, WARMUP=0, bit-exact pass-through with ready toggling
        check("t5_rst_fill", b_fill, 0);
        check("t5_rst_valid", b_valid, 0);
        b_reset = 1'b1;
        b_fir_y = 16'hFFFF; b_ready = 1'b1; step();
        check("t5_c1_valid", b_valid, 1);
        check("t5_c1_data",  b_data,  16'hFFFF);
        b_fir_y = 16'h0000; b_ready = 1'b0; step();
        check("t5_c2_hold",  b_data,  16'hFFFF);
        check("t5_c2_fill",  b_fill,  2);
        b_fir_y = 16'h8001; b_ready = 1'b1; step();
        check("t5_c3_data",  b_data,  16'h0000);
        b_fir_y = 16'h1111; b_ready = 1'b0; step();
        check("t5_c4_hold",  b_data,  16'h0000);
        b_fir_y = 16'h2222; b_ready = 1'b1; step();
        check("t5_c5_data",  b_data,  16'h8001);
        b_fir_y = 16'h3333; b_ready = 1'b0; step();
        check("t5_c6_hold",  b_data,  16'h8001);
        check("t5_c6_fill",  b_fill,  4);
        check("t5_ovf",      b_ovf,   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
